regfile_read_arbiter: RTL and testbench
=======================================

Name: regfile_read_arbiter

Overview:
- Shares the single combinational read port of the 8 x 32-bit register file between two requesters.
- Each requester asks for a burst of 1-8 consecutive registers starting at a given address.
- The block arbitrates between requesters, sequences the read address with wrap-around, and registers the returned data.
- It sits between the register file read mux and two client engines, and drives the mux address directly.

Parameters:
- DATA_WIDTH, 32, width of a register / read data word
- ADDR_WIDTH, 3, register index width (8 registers)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 burst request, held until gnt0
- addr0  input  ADDR_WIDTH  requester 0 start register
- len0  input  3  requester 0 burst length minus 1 (0 = 1 word, 7 = 8 words)
- gnt0  output  1  one-cycle pulse, requester 0 burst accepted
- rvalid0  output  1  rdata valid for requester 0
- req1, addr1, len1, gnt1, rvalid1  same as above, for requester 1
- rd_addr  output  ADDR_WIDTH  address to register file read mux
- rd_data  input  DATA_WIDTH  combinational data from register file read mux
- rdata  output  DATA_WIDTH  registered read data, shared by both requesters
- rlast  output  1  marks final word of a burst, qualified by rvalid0/rvalid1
- busy  output  1  high while in BURST

Behaviour:
- Reset (async, reset_n=0) drives these outputs and state immediately:
  - state=IDLE; gnt0, gnt1, rvalid0, rvalid1, rlast = 0; rdata=0; rd_addr=0; busy=0.
  - internal word counter cnt=0; owner=0; last_owner=1, so requester 0 wins the first contention.
- FSM states: IDLE, BURST.
- IDLE:
  - req0/req1 are sampled only in IDLE.
  - On a clock edge with any req high, select the winner (see Optional Feature).
  - Latch owner, len, and rd_addr<=addr of the winner; set cnt<=0.
  - Pulse gnt_owner=1 for exactly the next cycle; state<=BURST; last_owner<=owner.
  - No req: stay in IDLE, outputs unchanged except valids/gnts, which are 0.
- BURST, on each edge:
  - rdata<=rd_data; rvalid_owner<=1; rlast<=(cnt==len).
  - rd_addr<=rd_addr+1, 3-bit wrap (7->0); cnt<=cnt+1.
  - If cnt==len: state<=IDLE.
- Latency and throughput:
  - gnt is visible the cycle after the request is sampled.
  - First rvalid is one cycle after gnt.
  - len+1 words are delivered on consecutive cycles with no gaps.
- Back-to-back bursts: there is one idle cycle between the final rvalid of a burst and the next gnt (the request is re-sampled in IDLE).
- Requester obligations:
  - Hold req/addr/len stable until gnt.
  - Deassert req in the cycle gnt is seen, otherwise it is taken as a new request.
- Changes to req/addr/len during BURST are ignored; a burst always completes unless reset.
- The non-owner's rvalid stays 0 throughout a burst, and never both rvalid0 and rvalid1 are high.
- Reset asserted mid-burst aborts the burst immediately: all valids drop, and no further words are delivered after release.
- rd_data is assumed stable for the cycle in which rd_addr is presented (the register file read is combinational).

Optional Feature:
- Macro: RF_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On simultaneous req0 and req1 in IDLE, grant the requester that is not last_owner. A single request is granted regardless of last_owner.
- Undefined: fixed priority. req0 always wins over req1, and last_owner is unused (req1 can starve).

Test Plan:
- Registers preloaded as reg0..reg7 = ffff_ffff, 1111_1111, 1234_5678, 1357_9bdf, abcd_1234, ef12_6793, 9876_5432, 2468_acde.
  - req0 with addr0=3, len0=0 -> gnt0 one cycle later; next cycle rvalid0=1, rlast=1, rdata=1357_9bdf; then busy=0.
  - req1 with addr1=6, len1=3 -> rvalid1 on 4 consecutive cycles with rdata 9876_5432, 2468_acde, ffff_ffff, 1111_1111; rlast only on the 4th; rvalid0 stays 0.
- req0 and req1 asserted together, both held and re-asserted after each burst, with len=1:
  - RF_ARB_ROUND_ROBIN_EN defined -> grant order 0,1,0,1.
  - Macro undefined -> grant order 0,0,0.
- req0 with addr0=0, len0=7 -> 8 words reg0..reg7 in order, rd_addr sequence 0..7; req1 raised mid-burst is not granted until one idle cycle after rlast.
- reset_n pulled low during the 3rd word of a 6-word burst -> rvalid0/1, gnt, busy and rdata are 0 immediately; after release the block is in IDLE with no further rvalid until a new req.
- req0 deasserted mid-burst (addr0=2, len0=2) -> all 3 words still delivered: 1234_5678, 1357_9bdf, abcd_1234.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: shares the single combinational register-file read port
// between two requesters. Each request asks for a burst of 1-8 consecutive
// registers; the block arbitrates, walks the read address with wrap-around and
// registers the returned words.
//
// Optional feature: define RF_ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise requester 0 has fixed priority.
module regfile_read_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [2:0]            len0,
    output logic                  gnt0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [2:0]            len1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,
    output logic                  busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0] state;
    logic       owner;
    logic [2:0] len;
    logic [2:0] cnt;
    logic       win;

`ifdef RF_ARB_ROUND_ROBIN_EN
    // Last granted requester; reset to 1 so requester 0 wins the first tie.
    logic       last_owner;
`endif

    // Winner selection among the current requests (1 = requester 1)
    always_comb begin
        win = ~req0;
`ifdef RF_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            win = ~last_owner;
        end
`endif
    end

    // Arbitration and burst sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            len     <= 3'd0;
            cnt     <= 3'd0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rd_addr <= '0;
`ifdef RF_ARB_ROUND_ROBIN_EN
            last_owner <= 1'b1;
`endif
        end else if (state == IDLE) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (req0 || req1) begin
                owner   <= win;
                len     <= win ? len1 : len0;
                rd_addr <= win ? addr1 : addr0;
                cnt     <= 3'd0;
                gnt0    <= ~win;
                gnt1    <= win;
                state   <= BURST;
`ifdef RF_ARB_ROUND_ROBIN_EN
                last_owner <= win;
`endif
            end
        end else begin
            // One word per cycle; rd_data reflects the address presented now.
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rdata   <= rd_data;
            rvalid0 <= ~owner;
            rvalid1 <= owner;
            rlast   <= (cnt == len);
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
            cnt     <= cnt + 3'd1;
            if (cnt == len) begin
                state <= IDLE;
            end
        end
    end

    assign busy = (state == BURST);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: directed steps push expected
// words into a scoreboard; a monitor pops and compares each delivered word.
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic [2:0]  addr0, addr1, len0, len1;
    logic        gnt0, gnt1, rvalid0, rvalid1, rlast, busy;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data, rdata;

    logic [31:0] regs [8];

    typedef struct packed {
        logic        own;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    regfile_read_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .addr0(addr0), .len0(len0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .addr1(addr1), .len1(len1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rd_addr(rd_addr), .rd_data(rd_data), .rdata(rdata), .rlast(rlast), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic o, input logic [2:0] a, input logic [2:0] l,
                              input int n);
        for (int i = 0; i < n; i++) begin
            logic [2:0] ad;
            exp_t e;
            ad     = a + 3'(i);
            e.own  = o;
            e.data = regs[ad];
            e.last = (i == int'(l));
            sb.push_back(e);
        end
    endtask

    // Returns the number of cycles until the requested grant appears.
    task automatic wait_gnt(input logic o, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            step();
            cyc++;
            if ((o ? gnt1 : gnt0) === 1'b1) got = 1'b1;
        end
        check("gnt_timeout", {31'b0, got}, 32'd1);
    endtask

    task automatic wait_any(output logic w);
        logic got;
        int   cyc;
        got = 1'b0;
        cyc = 0;
        w   = 1'b0;
        while (!got && cyc < 20) begin
            step();
            cyc++;
            if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
                got = 1'b1;
                w   = gnt1;
            end
        end
        check("any_gnt_timeout", {31'b0, got}, 32'd1);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 20) begin
            step();
            cyc++;
        end
        check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    // Scoreboard monitor: every delivered word must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (rvalid0 === 1'b1 && rvalid1 === 1'b1) begin
                check("both_rvalid", 32'd1, 32'd0);
            end
            if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", {29'b0, rd_addr}, 32'hffff_ffff);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("mon_owner", {31'b0, rvalid1}, {31'b0, e.own});
                    check("mon_rdata", rdata, e.data);
                    check("mon_rlast", {31'b0, rlast}, {31'b0, e.last});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   n_order;
        int   exp_order [4];
        logic w;

        regs[0] = 32'hffff_ffff; regs[1] = 32'h1111_1111;
        regs[2] = 32'h1234_5678; regs[3] = 32'h1357_9bdf;
        regs[4] = 32'habcd_1234; regs[5] = 32'hef12_6793;
        regs[6] = 32'h9876_5432; regs[7] = 32'h2468_acde;

        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 3'd0; addr1 = 3'd0; len0 = 3'd0; len1 = 3'd0;
        #2;
        check("rst_gnt0", {31'b0, gnt0}, 32'd0);
        check("rst_gnt1", {31'b0, gnt1}, 32'd0);
        check("rst_rvalid", {30'b0, rvalid0, rvalid1}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rd_addr", {29'b0, rd_addr}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Single word from requester 0
        req0 = 1'b1; addr0 = 3'd3; len0 = 3'd0;
        wait_gnt(1'b0, cyc);
        check("t1_gnt_latency", cyc, 32'd1);
        check("t1_gnt1_low", {31'b0, gnt1}, 32'd0);
        req0 = 1'b0;
        push_burst(1'b0, 3'd3, 3'd0, 1);
        step();
        check("t1_rvalid0", {31'b0, rvalid0}, 32'd1);
        check("t1_rlast", {31'b0, rlast}, 32'd1);
        check("t1_rdata", rdata, 32'h1357_9bdf);
        check("t1_busy", {31'b0, busy}, 32'd0);
        step();

        // Four words from requester 1 with address wrap
        req1 = 1'b1; addr1 = 3'd6; len1 = 3'd3;
        wait_gnt(1'b1, cyc);
        req1 = 1'b0;
        push_burst(1'b1, 3'd6, 3'd3, 4);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_rvalid1", {31'b0, rvalid1}, 32'd1);
            check("t2_rvalid0", {31'b0, rvalid0}, 32'd0);
            check("t2_rlast", {31'b0, rlast}, (i == 3) ? 32'd1 : 32'd0);
        end
        step();
        check("t2_rvalid1_end", {31'b0, rvalid1}, 32'd0);

        // Contention, both requesters re-requesting after each burst
`ifdef RF_ARB_ROUND_ROBIN_EN
        n_order = 4;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`else
        n_order = 3;
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`endif
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 3'd0; len0 = 3'd1; addr1 = 3'd4; len1 = 3'd1;
        for (int k = 0; k < n_order; k++) begin
            wait_any(w);
            check("t3_order", {31'b0, w}, exp_order[k]);
            if (w) req1 = 1'b0; else req0 = 1'b0;
            push_burst(w, w ? 3'd4 : 3'd0, 3'd1, 2);
            wait_idle();
            if (k < n_order - 1) begin
                if (w) req1 = 1'b1; else req0 = 1'b1;
            end else begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        step();

        // Full 8-word burst; req1 raised mid-burst waits for the idle cycle
        req0 = 1'b1; addr0 = 3'd0; len0 = 3'd7;
        wait_gnt(1'b0, cyc);
        req0 = 1'b0;
        push_burst(1'b0, 3'd0, 3'd7, 8);
        for (int i = 0; i <= 9; i++) begin
            if (i <= 8) begin
                check("t4_rd_addr", {29'b0, rd_addr}, i % 8);
                check("t4_gnt1_low", {31'b0, gnt1}, 32'd0);
            end
            if (i == 3) begin
                req1 = 1'b1; addr1 = 3'd1; len1 = 3'd0;
            end
            if (i == 8) begin
                check("t4_rlast", {31'b0, rlast}, 32'd1);
                check("t4_busy_idle", {31'b0, busy}, 32'd0);
            end
            if (i == 9) begin
                check("t4_gnt1", {31'b0, gnt1}, 32'd1);
                req1 = 1'b0;
                push_burst(1'b1, 3'd1, 3'd0, 1);
            end
            if (i < 9) step();
        end
        wait_idle();
        step();

        // Reset during the third word of a six-word burst
        req0 = 1'b1; addr0 = 3'd1; len0 = 3'd5;
        wait_gnt(1'b0, cyc);
        req0 = 1'b0;
        push_burst(1'b0, 3'd1, 3'd5, 2);
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("t5_rvalid", {30'b0, rvalid0, rvalid1}, 32'd0);
        check("t5_gnt", {30'b0, gnt0, gnt1}, 32'd0);
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_rdata", rdata, 32'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_quiet", {29'b0, rvalid0, rvalid1, busy}, 32'd0);
        end

        // Requester inputs changed during a burst are ignored
        req0 = 1'b1; addr0 = 3'd2; len0 = 3'd2;
        wait_gnt(1'b0, cyc);
        req0 = 1'b0; addr0 = 3'd7; len0 = 3'd7;
        push_burst(1'b0, 3'd2, 3'd2, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_rvalid0", {31'b0, rvalid0}, 32'd1);
        end
        step();
        check("t6_done", {30'b0, rvalid0, busy}, 32'd0);

        step();
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
